note_recorder: RTL and testbench
================================

Name: note_recorder

Overview:
- Record-mode counterpart of the play-mode path. It samples the user's note keys and octave shift at a fixed beat rate.
- Each sample is packed into a 10-bit note word: notes in bits 9:2, shift in bits 1:0.
- Words are written sequentially into the song memory that play mode later reads back and feeds to the buzzer.
- Sits between the key/switch inputs and the write port of the song memory block.

Parameters:
- TICK_CYCLES, 25_000_000: clk cycles per sample beat (0.25 s at 100 MHz).
- DEPTH, 384: memory words available; equals the display length.
- ADDR_W, 9: width of the memory address.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- isRecord  in  1  record mode selected; level signal
- notes  in  8  note keys, one bit per key, raw from the board
- shift  in  2  octave shift, raw from the board
- wr_en  out  1  one-cycle write strobe to memory
- wr_addr  out  ADDR_W  write address
- wr_data  out  10  note word {notes, shift}
- rec_len  out  ADDR_W+1  number of words recorded
- full  out  1  memory exhausted
- busy  out  1  high in ARMED and RECORD

Behaviour:
- Reset values (asynchronous): state IDLE; wr_en=0, wr_addr=0, wr_data=0, rec_len=0, full=0, busy=0; tick counter=0; synchronizers cleared. Reset mid-recording discards the take (rec_len=0).
- Input synchronizers: notes, shift and isRecord each pass through a 2-flop synchronizer. All timing below refers to the synchronized values (s_*).
- Start detection: a rising edge of s_isRecord in IDLE moves to ARMED. On that transition wr_addr, rec_len and full are cleared.
- ARMED: waits for s_notes != 0 (leading silence is not recorded).
  - On the first cycle s_notes != 0: go to RECORD and clear the tick counter to 0.
  - The next cycle (first RECORD cycle) issues wr_en=1 with wr_data={s_notes,s_shift} sampled on the transition cycle, at wr_addr=0.
- RECORD:
  - The tick counter runs 0..TICK_CYCLES-1 and wraps.
  - Each wrap (counter == TICK_CYCLES-1) issues one wr_en pulse with the current {s_notes,s_shift}. Zero notes are written as rests.
  - After every write: wr_addr += 1 and rec_len += 1, registered in the cycle after the wr_en cycle. wr_addr/wr_data are stable while wr_en is high.
- Full: when rec_len reaches DEPTH, set full=1 and go to DONE; no further writes. wr_addr never exceeds DEPTH-1 on a write.
- Stop: s_isRecord low in ARMED or RECORD goes to DONE.
  - From ARMED this gives rec_len=0.
  - If a beat write and the stop occur in the same cycle, the write still issues, then DONE.
- DONE: busy=0. rec_len and full hold. Return to IDLE when s_isRecord=0. A new take needs a fresh rising edge.
- wr_en is never high in IDLE, ARMED or DONE (except the marker write below).
- busy=1 exactly in ARMED and RECORD.

Optional Feature:
- Macro: NOTE_RECORDER_END_MARKER_EN.
- Defined: on entering DONE with full=0, a FINISH state issues one extra wr_en pulse with wr_data=10'h3FF at the current wr_addr, then goes to DONE. rec_len excludes the marker; no marker is written when full=1.
- Undefined: no FINISH state, and no write occurs after the last beat.

Test Plan (TICK_CYCLES=4, DEPTH=8):
- Reset mid-RECORD (rst pulse after 3 writes) -> all outputs return to zero immediately; rec_len=0; state IDLE.
- isRecord=1, notes=0 for 20 cycles, then notes=8'h04, shift=2'b01 -> no writes while notes=0. First write: wr_addr=0, wr_data=10'h011, 3 cycles after notes change (2 sync + 1). Next writes every 4 cycles at addresses 1, 2, ...
- Keys held through 8 beats with isRecord kept high -> exactly 8 writes (addresses 0..7); full=1, busy=0, rec_len=8; no further wr_en.
- Notes pattern 04, 00, 10 across beats, then isRecord low -> wr_data sequence 10'h011, 10'h001, 10'h041 (shift=01); rec_len=3; DONE, then IDLE.
- isRecord rises and falls with no key pressed -> no writes, rec_len=0. With the marker macro defined: one write of 10'h3FF at address 0.
- Beat write coincides with s_isRecord falling -> that write occurs and rec_len counts it. With the marker macro defined, the marker lands at the next address.

Source files
------------

// File: rtl/note_recorder.sv
// Record-mode sampler: packs {notes, shift} into 10-bit words once per beat and streams them to the song memory.
// Optional end-of-take marker write (10'h3FF) when NOTE_RECORDER_END_MARKER_EN is defined.
module note_recorder #(
  parameter int TICK_CYCLES = 25_000_000,
  parameter int DEPTH       = 384,
  parameter int ADDR_W      = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isRecord,
  input  logic [7:0]        notes,
  input  logic [1:0]        shift,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [9:0]        wr_data,
  output logic [ADDR_W:0]   rec_len,
  output logic              full,
  output logic              busy
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [ADDR_W:0] LEN_LAST  = (ADDR_W+1)'(DEPTH - 1);

`ifdef NOTE_RECORDER_END_MARKER_EN
  typedef enum logic [2:0] {IDLE, ARMED, RECORD, FINISH, DONE} state_t;
  localparam state_t STOP_ST = FINISH;
`else
  typedef enum logic [1:0] {IDLE, ARMED, RECORD, DONE} state_t;
  localparam state_t STOP_ST = DONE;
`endif

  state_t        state;
  logic [TW-1:0] tick;
  logic [7:0]    notes_m, s_notes;
  logic [1:0]    shift_m, s_shift;
  logic          rec_m, s_rec, s_rec_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tick    <= '0;
      notes_m <= '0;
      s_notes <= '0;
      shift_m <= '0;
      s_shift <= '0;
      rec_m   <= 1'b0;
      s_rec   <= 1'b0;
      s_rec_d <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rec_len <= '0;
      full    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      notes_m <= notes;
      s_notes <= notes_m;
      shift_m <= shift;
      s_shift <= shift_m;
      rec_m   <= isRecord;
      s_rec   <= rec_m;
      s_rec_d <= s_rec;
      wr_en   <= 1'b0;

      // Beat writes only ever happen in RECORD; the marker (in DONE) is not counted.
      if (wr_en && state == RECORD) begin
        wr_addr <= wr_addr + 1'b1;
        rec_len <= rec_len + 1'b1;
      end

      case (state)
        IDLE: begin
          if (s_rec && !s_rec_d) begin
            state   <= ARMED;
            busy    <= 1'b1;
            wr_addr <= '0;
            rec_len <= '0;
            full    <= 1'b0;
          end
        end
        ARMED: begin
          if (!s_rec) begin
            state <= STOP_ST;
            busy  <= 1'b0;
          end else if (s_notes != '0) begin
            state   <= RECORD;
            tick    <= '0;
            wr_en   <= 1'b1;
            wr_data <= {s_notes, s_shift};
          end
        end
        RECORD: begin
          tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
          if (wr_en && rec_len == LEN_LAST) begin
            full  <= 1'b1;
            state <= DONE;
            busy  <= 1'b0;
          end else if (tick == TICK_LAST && (s_rec || !wr_en)) begin
            // A beat coinciding with stop still writes; the stop is taken next cycle.
            wr_en   <= 1'b1;
            wr_data <= {s_notes, s_shift};
          end else if (!s_rec) begin
            state <= STOP_ST;
            busy  <= 1'b0;
          end
        end
`ifdef NOTE_RECORDER_END_MARKER_EN
        FINISH: begin
          wr_en   <= 1'b1;
          wr_data <= 10'h3FF;
          state   <= DONE;
        end
`endif
        DONE: begin
          if (!s_rec) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: directed table of takes, hand sequences, and random takes checked against a beat-schedule model.
module tb_note_recorder;
  localparam int T  = 4;
  localparam int D  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          isRecord;
  logic [7:0]    notes;
  logic [1:0]    shift;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [9:0]    wr_data;
  logic [AW:0]   rec_len;
  logic          full;
  logic          busy;

  always #5 clk = ~clk;

  note_recorder #(.TICK_CYCLES(T), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .isRecord(isRecord), .notes(notes), .shift(shift),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rec_len(rec_len), .full(full), .busy(busy)
  );

  typedef struct {int cyc; logic [AW-1:0] addr; logic [9:0] data;} wr_t;
  typedef struct {
    int         z;
    logic [7:0] n;
    logic [1:0] sh;
    int         h;
    int         cnt;
    logic [9:0] d;
    logic [9:0] dl;
    logic       f;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  wr_t  got[$];
  wr_t  exp_q[$];
  logic in_rec[$];
  logic [7:0] in_n[$];
  logic [1:0] in_s[$];
  logic bq[$];
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic clr_take();
    in_rec.delete(); in_n.delete(); in_s.delete();
  endtask

  task automatic push_n(input int cnt, input logic r, input logic [7:0] n, input logic [1:0] s);
    for (int i = 0; i < cnt; i++) begin
      in_rec.push_back(r); in_n.push_back(n); in_s.push_back(s);
    end
  endtask

  task automatic build_take(input int z, input logic [7:0] n, input logic [1:0] sh, input int h);
    clr_take();
    push_n(3, 1'b0, 8'h00, sh);
    push_n(z, 1'b1, 8'h00, sh);
    push_n(h, 1'b1, n, sh);
    push_n(10, 1'b0, 8'h00, sh);
  endtask

  // Input for index c is driven at the negedge of cycle c; outputs seen at that negedge belong to cycle c.
  task automatic run_take();
    got.delete(); bq.delete();
    for (int c = 0; c < in_rec.size(); c++) begin
      @(negedge clk);
      if (wr_en === 1'b1) got.push_back('{c, wr_addr, wr_data});
      bq.push_back(busy);
      isRecord = in_rec[c];
      notes    = in_n[c];
      shift    = in_s[c];
    end
  endtask

  function automatic logic srec(input int c);
    return (c >= 2) ? in_rec[c-2] : 1'b0;
  endfunction

  // Beat schedule: first word one cycle after the first keyed synchronized sample,
  // then one word every T cycles while record is held (a beat on the stop cycle still counts).
  task automatic model_take(output int nb);
    int a, t0, ts, n;
    n = in_rec.size();
    exp_q.delete();
    nb = 0; a = -1; t0 = -1; ts = n + 1000;
    for (int c = 1; c < n; c++)
      if (a < 0 && srec(c) && !srec(c-1)) a = c;
    if (a >= 0) begin
      for (int c = a + 1; c < n; c++) begin
        if (!srec(c)) break;
        if (in_n[c-2] != 8'h00) begin t0 = c; break; end
      end
    end
    if (t0 >= 0) begin
      for (int c = t0 + 1; c < n; c++)
        if (ts > n && !srec(c)) ts = c;
      for (int k = 0; k < D; k++) begin
        int cs;
        cs = t0 + k * T;
        if (k > 0 && cs > ts) break;
        if (cs + 1 >= n) break;
        exp_q.push_back('{cs + 1, AW'(k), {in_n[cs-2], in_s[cs-2]}});
        nb++;
      end
    end
`ifdef NOTE_RECORDER_END_MARKER_EN
    if (a >= 0 && nb < D) exp_q.push_back('{-1, AW'(nb), 10'h3FF});
`endif
  endtask

  task automatic compare_take(input string tag, input int nb);
    int m;
    chk({tag, " wr_count"}, got.size(), exp_q.size());
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      if (exp_q[i].cyc >= 0) chk({tag, " wr_cycle"}, got[i].cyc, exp_q[i].cyc);
      chk({tag, " wr_addr"}, got[i].addr, exp_q[i].addr);
      chk({tag, " wr_data"}, got[i].data, exp_q[i].data);
    end
    chk({tag, " rec_len"}, rec_len, nb);
    chk({tag, " full"}, full, (nb == D));
    chk({tag, " busy_end"}, busy, 0);
  endtask

  initial begin
    int nb, z, l, ex;
    logic hit;
    tbl[0] = '{1,  8'h04, 2'd1, 3,  1, 10'h011, 10'h011, 1'b0};
    tbl[1] = '{20, 8'h04, 2'd1, 6,  2, 10'h011, 10'h011, 1'b0};
    tbl[2] = '{2,  8'h80, 2'd2, 4,  2, 10'h202, 10'h002, 1'b0};
    tbl[3] = '{5,  8'h01, 2'd0, 1,  1, 10'h004, 10'h004, 1'b0};
    tbl[4] = '{3,  8'h10, 2'd1, 8,  3, 10'h041, 10'h001, 1'b0};
    tbl[5] = '{1,  8'hA5, 2'd0, 40, 8, 10'h294, 10'h294, 1'b1};
    tbl[6] = '{6,  8'h00, 2'd0, 0,  0, 10'h000, 10'h000, 1'b0};

    rst = 1'b1; isRecord = 1'b0; notes = 8'h00; shift = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst rec_len", rec_len, 0);
    chk("rst full", full, 0);
    chk("rst busy", busy, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      build_take(tbl[v].z, tbl[v].n, tbl[v].sh, tbl[v].h);
      run_take();
      ex = tbl[v].cnt;
`ifdef NOTE_RECORDER_END_MARKER_EN
      if (!tbl[v].f) ex++;
`endif
      chk($sformatf("tbl%0d wr_count", v), got.size(), ex);
      for (int k = 0; k < got.size() && k < tbl[v].cnt; k++) begin
        chk($sformatf("tbl%0d wr_cycle", v), got[k].cyc, tbl[v].z + 6 + k * T);
        chk($sformatf("tbl%0d wr_addr", v), got[k].addr, k);
        chk($sformatf("tbl%0d wr_data", v), got[k].data,
            (k == tbl[v].cnt - 1) ? tbl[v].dl : tbl[v].d);
      end
`ifdef NOTE_RECORDER_END_MARKER_EN
      if (!tbl[v].f && got.size() > tbl[v].cnt) begin
        chk($sformatf("tbl%0d marker_addr", v), got[tbl[v].cnt].addr, tbl[v].cnt);
        chk($sformatf("tbl%0d marker_data", v), got[tbl[v].cnt].data, 10'h3FF);
      end
`endif
      chk($sformatf("tbl%0d rec_len", v), rec_len, tbl[v].cnt);
      chk($sformatf("tbl%0d full", v), full, tbl[v].f);
      chk($sformatf("tbl%0d busy", v), busy, 0);
    end

    // Pattern 04, 00, 10 over three beats, released before the fourth beat.
    clr_take();
    push_n(3, 1'b0, 8'h00, 2'd1);
    push_n(1, 1'b1, 8'h00, 2'd1);
    push_n(4, 1'b1, 8'h04, 2'd1);
    push_n(4, 1'b1, 8'h00, 2'd1);
    push_n(2, 1'b1, 8'h10, 2'd1);
    push_n(10, 1'b0, 8'h00, 2'd1);
    run_take();
`ifdef NOTE_RECORDER_END_MARKER_EN
    chk("pat wr_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("pat marker_addr", got[3].addr, 3);
      chk("pat marker_data", got[3].data, 10'h3FF);
    end
`else
    chk("pat wr_count", got.size(), 3);
`endif
    if (got.size() >= 3) begin
      chk("pat d0", got[0].data, 10'h011);
      chk("pat d1", got[1].data, 10'h001);
      chk("pat d2", got[2].data, 10'h041);
      chk("pat c0", got[0].cyc, 7);
      chk("pat c2", got[2].cyc, 15);
      chk("pat a2", got[2].addr, 2);
    end
    chk("pat busy5", bq[5], 0);
    chk("pat busy6", bq[6], 1);
    chk("pat busy16", bq[16], 1);
    chk("pat busy17", bq[17], 0);
    chk("pat rec_len", rec_len, 3);

    // Reset in the middle of a take after three words.
    build_take(1, 8'h04, 2'd1, 40);
    got.delete();
    hit = 1'b0;
    for (int c = 0; c < 100 && c < in_rec.size(); c++) begin
      @(negedge clk);
      if (wr_en === 1'b1) got.push_back('{c, wr_addr, wr_data});
      if (got.size() == 3) begin hit = 1'b1; break; end
      isRecord = in_rec[c]; notes = in_n[c]; shift = in_s[c];
    end
    chk("midrst reached_3_writes", hit, 1);
    rst = 1'b1;
    #1;
    chk("midrst wr_en", wr_en, 0);
    chk("midrst wr_addr", wr_addr, 0);
    chk("midrst wr_data", wr_data, 0);
    chk("midrst rec_len", rec_len, 0);
    chk("midrst full", full, 0);
    chk("midrst busy", busy, 0);
    isRecord = 1'b0; notes = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int t = 0; t < 30; t++) begin
      clr_take();
      z = $urandom_range(0, 6);
      l = $urandom_range(1, 45);
      for (int i = 0; i < 3; i++) push_n(1, 1'b0, 8'($urandom), 2'($urandom));
      for (int i = 0; i < l; i++)
        push_n(1, 1'b1, (i < z || $urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 2'($urandom));
      for (int i = 0; i < 10; i++) push_n(1, 1'b0, 8'($urandom), 2'($urandom));
      run_take();
      model_take(nb);
      compare_take($sformatf("rnd%0d", t), nb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
